// File: rtl/tt_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tt_sweep_checker
//  Description : Exhaustive truth-table sweeper for a 3-input gate.
//                On a start pulse it walks {a,b,c} through 000..111. Each
//                vector is held for DWELL cycles and then sampled for one
//                cycle, where y is compared with EXP_TT[{a,b,c}]. At the
//                end it holds a pass flag, a mismatch count and a per-vector
//                fail mask until the next start.
//
//  Parameters  : DWELL  - cycles each vector is held before y is sampled
//                         (1..255)
//                EXP_TT - expected y per vector, bit index = {a,b,c}
//
//  Ports       : clk       in   single clock, rising edge
//                rst_n     in   asynchronous active-low reset
//                start     in   one-cycle sweep request (IDLE/DONE only)
//                a,b,c     out  vector to the gate under test (a = MSB)
//                y         in   gate-under-test response
//                busy      out  sweep in progress (APPLY/SAMPLE)
//                done      out  result held (DONE)
//                pass      out  DONE with no mismatches
//                err_cnt   out  number of mismatching vectors (0..8)
//                fail_mask out  bit i set when vector i mismatched
//
//  Option      : TT_SWEEP_STOP_ON_FAIL_EN - when defined, the first
//                mismatch ends the sweep immediately (err_cnt = 1).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_checker #(
    parameter int unsigned DWELL  = 4,
    parameter logic [7:0]  EXP_TT = 8'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_mask
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] C_DWELL_LAST = 8'(DWELL - 1);
    localparam logic [3:0] C_ERR_MAX    = 4'd8;

    state_t     r_state;
    logic [2:0] r_vec;
    logic [7:0] r_dwell;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_cnt;
    logic [7:0] r_fail_mask;

    logic       w_mismatch;
    logic [3:0] w_err_after;
    logic       w_finish;

    // y is only meaningful in SAMPLE; elsewhere the result is ignored.
    assign w_mismatch  = (y != EXP_TT[r_vec]);

    // Count including the current sample, saturating at the vector count.
    assign w_err_after = (w_mismatch && (r_err_cnt != C_ERR_MAX)) ?
                         (r_err_cnt + 4'd1) : r_err_cnt;

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    assign w_finish = (r_vec == 3'd7) || w_mismatch;
`else
    assign w_finish = (r_vec == 3'd7);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vec       <= 3'd0;
            r_dwell     <= 8'd0;
            r_abc       <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= 4'd0;
            r_fail_mask <= 8'd0;
        end else begin
            case (r_state)
                // IDLE and DONE share the start handling: a start in DONE
                // is a full restart with the previous result discarded.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_APPLY;
                        r_vec       <= 3'd0;
                        r_dwell     <= 8'd0;
                        r_abc       <= 3'd0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= 4'd0;
                        r_fail_mask <= 8'd0;
                    end
                end

                ST_APPLY: begin
                    r_dwell <= r_dwell + 8'd1;
                    if (r_dwell == C_DWELL_LAST) begin
                        r_state <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        r_err_cnt          <= w_err_after;
                        r_fail_mask[r_vec] <= 1'b1;
                    end
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_after == 4'd0);
                    end else begin
                        r_state <= ST_APPLY;
                        r_vec   <= r_vec + 3'd1;
                        r_dwell <= 8'd0;
                        r_abc   <= r_vec + 3'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a         = r_abc[2];
    assign b         = r_abc[1];
    assign c         = r_abc[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign fail_mask = r_fail_mask;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_sweep_checker
//  Description : Directed self-checking bench for tt_sweep_checker.
//                u_dut  : DWELL=4, gate model selectable (correct / y=0).
//                u_dut1 : DWELL=1, gate model inverted (every vector wrong).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a, b, c;
    logic       y;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [7:0] fail_mask;

    logic       start1;
    logic       a1, b1, c1;
    logic       y1;
    logic       busy1, done1, pass1;
    logic [3:0] err_cnt1;
    logic [7:0] fail_mask1;

    int mode;       // 0: correct gate, 1: y tied 0
    int n_checks;
    int n_errors;

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    localparam int         Y0_CYC     = 5;
    localparam logic [3:0] Y0_ERR     = 4'd1;
    localparam logic [7:0] Y0_MASK    = 8'h01;
    localparam logic       BUSY_AT_V3 = 1'b0;
    localparam int         INV_CYC    = 2;
    localparam logic [3:0] INV_ERR    = 4'd1;
    localparam logic [7:0] INV_MASK   = 8'h01;
`else
    localparam int         Y0_CYC     = 40;
    localparam logic [3:0] Y0_ERR     = 4'd3;
    localparam logic [7:0] Y0_MASK    = 8'h15;
    localparam logic       BUSY_AT_V3 = 1'b1;
    localparam int         INV_CYC    = 16;
    localparam logic [3:0] INV_ERR    = 4'd8;
    localparam logic [7:0] INV_MASK   = 8'hFF;
`endif

    tt_sweep_checker #(.DWELL(4), .EXP_TT(8'h15)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_mask (fail_mask)
    );

    tt_sweep_checker #(.DWELL(1), .EXP_TT(8'h15)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .y         (y1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_cnt   (err_cnt1),
        .fail_mask (fail_mask1)
    );

    // Gate models
    assign y  = (mode == 0) ? ~((a & b) | c) : 1'b0;
    assign y1 = (a1 & b1) | c1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep on u_dut. Returns cycles from the start edge to done.
    // ign_at > 0 pulses start again that many cycles into the sweep.
    task automatic sweep0(input string tag, input int ign_at, output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_enter"}, {busy, done, pass, err_cnt, fail_mask, a, b, c},
            {1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 3'd0});
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
            start = (cyc == ign_at);
            // After edge 5k+4 the DUT sits in SAMPLE for vector k.
            if (!done && (cyc % 5 == 4) && cyc < 40)
                chk({tag, "_walk"}, {busy, a, b, c}, {1'b1, 3'(cyc / 5)});
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int seen_done;
        n_checks = 0;
        n_errors = 0;
        mode     = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        start1   = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_outs", {busy, done, pass, err_cnt, fail_mask, a, b, c}, 19'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_outs", {busy, done, pass, err_cnt, fail_mask, a, b, c}, 19'd0);

        // Correct gate: full clean sweep
        sweep0("good", 0, cyc);
        chk("good_cycles", cyc, 40);
        chk("good_result", {busy, done, pass, err_cnt, fail_mask, a, b, c},
            {1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 3'd0});
        repeat (4) tick();
        chk("good_hold", {busy, done, pass, err_cnt, fail_mask}, {1'b0, 1'b1, 1'b1, 4'd0, 8'h00});

        // y tied 0, restarted from DONE
        mode = 1;
        sweep0("y0", 0, cyc);
        chk("y0_cycles", cyc, Y0_CYC);
        chk("y0_result", {busy, done, pass, err_cnt, fail_mask},
            {1'b0, 1'b1, 1'b0, Y0_ERR, Y0_MASK});

        // Restart from DONE clears the result; start during APPLY is ignored
        mode = 0;
        sweep0("restart", 2, cyc);
        chk("restart_cycles", cyc, 40);
        chk("restart_result", {busy, done, pass, err_cnt, fail_mask},
            {1'b0, 1'b1, 1'b1, 4'd0, 8'h00});

        // Reset during vector 3
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (17) tick();
        chk("v3_busy", busy, BUSY_AT_V3);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {busy, done, pass, err_cnt, fail_mask, a, b, c}, 19'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done || busy) seen_done++;
        end
        chk("no_resume", seen_done, 0);
        mode = 0;
        sweep0("post_rst", 0, cyc);
        chk("post_rst_cycles", cyc, 40);
        chk("post_rst_result", {busy, done, pass, err_cnt, fail_mask},
            {1'b0, 1'b1, 1'b1, 4'd0, 8'h00});

        // DWELL=1, inverted gate
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("inv_enter", {busy1, done1}, 2'b10);
        cyc = 0;
        while (!done1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("inv_cycles", cyc, INV_CYC);
        chk("inv_result", {busy1, done1, pass1, err_cnt1, fail_mask1, a1, b1, c1},
            {1'b0, 1'b1, 1'b0, INV_ERR, INV_MASK, 3'd0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
